// File: rtl/key_filter_pkg.sv
// Shared types and defaults for the key debounce filter.
package key_filter_pkg;

  localparam int unsigned CNT_MAX_DEF  = 999_999;     // 20 ms at 50 MHz, minus one
  localparam int unsigned LONG_MAX_DEF = 49_999_999;  // 1 s at 50 MHz, minus one

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILTER0 = 2'd1,
    DOWN    = 2'd2,
    FILTER1 = 2'd3
  } state_t;

  // Counter width large enough to reach the larger of the two limits
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/key_sync_edge.sv
// Two-flop synchronizer plus an edge register for the raw key input.
// Everything resets to 1 (released) so no edge is seen after reset.
module key_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic level,
  output logic nedge,
  output logic pedge
);

  logic sync1;
  logic sync2;
  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= key_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign level = sync2;
  assign nedge = prev & ~sync2;
  assign pedge = ~prev & sync2;

endmodule

// File: rtl/key_filter.sv
// Mechanical key debouncer: press/release qualification FSM with flag and level outputs.
// Define KEY_FILTER_LONG_PRESS_EN to build the long-press hold counter driving key_long.
module key_filter
  import key_filter_pkg::*;
#(
  parameter int unsigned CNT_MAX  = CNT_MAX_DEF,
  parameter int unsigned LONG_MAX = LONG_MAX_DEF
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic key_in,
  output logic key_flag,
  output logic key_state,
  output logic key_long
);

  localparam int unsigned CNT_W = cnt_width(CNT_MAX, LONG_MAX);

  logic             level;
  logic             nedge;
  logic             pedge;
  state_t           state;
  logic [CNT_W-1:0] cnt;

  key_sync_edge u_sync_edge (
    .clk    (Clk),
    .rst_n  (Rst_n),
    .key_in (key_in),
    .level  (level),
    .nedge  (nedge),
    .pedge  (pedge)
  );

  // Qualification FSM; an edge always wins over a completed count
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      key_flag  <= 1'b0;
      key_state <= 1'b1;
    end else begin
      key_flag <= 1'b0;
      case (state)
        IDLE: begin
          if (nedge) begin
            state <= FILTER0;
            cnt   <= '0;
          end
        end
        FILTER0: begin
          if (pedge) begin
            state <= IDLE;
            cnt   <= '0;
          end else if ((cnt == CNT_W'(CNT_MAX)) && !level) begin
            state     <= DOWN;
            cnt       <= '0;
            key_flag  <= 1'b1;
            key_state <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DOWN: begin
          if (pedge) begin
            state <= FILTER1;
            cnt   <= '0;
          end
        end
        FILTER1: begin
          if (nedge) begin
            state <= DOWN;
            cnt   <= '0;
          end else if ((cnt == CNT_W'(CNT_MAX)) && level) begin
            state     <= IDLE;
            cnt       <= '0;
            key_flag  <= 1'b1;
            key_state <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef KEY_FILTER_LONG_PRESS_EN
  logic [CNT_W-1:0] hold;
  logic             hold_done;

  // Hold timer restarts on every DOWN entry and fires once per press
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      hold      <= '0;
      hold_done <= 1'b0;
      key_long  <= 1'b0;
    end else begin
      key_long <= 1'b0;
      if ((state != DOWN) || pedge) begin
        hold      <= '0;
        hold_done <= 1'b0;
      end else if (!hold_done) begin
        if (hold == CNT_W'(LONG_MAX)) begin
          key_long  <= 1'b1;
          hold_done <= 1'b1;
        end else begin
          hold <= hold + CNT_W'(1);
        end
      end
    end
  end
`else
  assign key_long = 1'b0;
`endif

endmodule

// File: tb/tb_key_filter.sv
// Randomized bench for key_filter against a sample-history reference model.
module tb_key_filter;

  localparam int CNT_MAX  = 99;
  localparam int LONG_MAX = 999;
  localparam int FLAG_LAT = CNT_MAX + 4;

  logic Clk    = 1'b0;
  logic Rst_n  = 1'b0;
  logic key_in = 1'b1;
  logic key_flag;
  logic key_state;
  logic key_long;

  int n_checks = 0;
  int n_errors = 0;
  int flag_cnt = 0;
  int long_cnt = 0;
  bit chk_en   = 1'b0;

  key_filter #(
    .CNT_MAX  (CNT_MAX),
    .LONG_MAX (LONG_MAX)
  ) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .key_in    (key_in),
    .key_flag  (key_flag),
    .key_state (key_state),
    .key_long  (key_long)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: debounced level flips once the synchronised input (two samples
  // late) has held the opposite value for CNT_MAX+2 consecutive samples;
  // long press fires LONG_MAX+1 cycles after the low level last (re)started
  // while debounced-pressed.
  typedef struct packed {
    logic [3:0] hist;
    logic       state;
    int         run;
    int         age;
    logic       flag;
    logic       lng;
  } model_t;

  localparam model_t MODEL_RST = '{hist: 4'hF, state: 1'b1, run: 0, age: 0, flag: 1'b0, lng: 1'b0};

  function automatic model_t model_step(input model_t m, input logic k);
    model_t n = m;
    logic   lvl;
    logic   chg;
    n.hist = {m.hist[2:0], k};
    lvl    = n.hist[2];
    chg    = n.hist[2] != n.hist[3];
    n.run  = chg ? 1 : m.run + 1;
    n.flag = 1'b0;
    n.lng  = 1'b0;
    if ((lvl != m.state) && (n.run == CNT_MAX + 2)) begin
      n.flag  = 1'b1;
      n.state = lvl;
    end
    if (!n.state && !lvl) begin
      if (n.flag || chg) n.age = 0;
      else begin
        n.age = m.age + 1;
        n.lng = (n.age == LONG_MAX + 1);
      end
    end
    return n;
  endfunction

  model_t m;

  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) m <= MODEL_RST;
    else        m <= model_step(m, key_in);
  end

  // Cycle-by-cycle comparison against the model, plus pulse counting
  always @(negedge Clk) begin
    if (Rst_n) begin
      if (key_flag) flag_cnt++;
      if (key_long) long_cnt++;
      if (chk_en) begin
        check("flag", key_flag, m.flag);
        check("state", key_state, m.state);
`ifdef KEY_FILTER_LONG_PRESS_EN
        check("long", key_long, m.lng);
`else
        check("long", key_long, 0);
`endif
      end
    end
  end

  task automatic wait_flag(input int bound, output int lat);
    lat = -1;
    for (int i = 1; i <= bound; i++) begin
      @(negedge Clk);
      if (key_flag) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic wait_long(input int bound, output int lat);
    lat = -1;
    for (int i = 1; i <= bound; i++) begin
      @(negedge Clk);
      if (key_long) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic bounce(input logic final_level);
    for (int i = 0; i < 50; i++) begin
      repeat ($urandom_range(1, 60)) @(negedge Clk);
      key_in = ~key_in;
    end
    if (key_in != final_level) begin
      repeat ($urandom_range(1, 60)) @(negedge Clk);
      key_in = final_level;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: bench did not finish, errors=%0d", n_errors);
    $fatal(1);
  end

  initial begin
    int lat;
    int f0;
    int l0;

    repeat (3) @(negedge Clk);
    check("rst_flag", key_flag, 0);
    check("rst_state", key_state, 1);
    check("rst_long", key_long, 0);
    Rst_n  = 1'b1;
    chk_en = 1'b1;
    repeat (10) @(negedge Clk);

    // Clean press and release
    f0 = flag_cnt; l0 = long_cnt;
    key_in = 1'b0;
    wait_flag(300, lat);
    check("press_lat", lat, FLAG_LAT);
    check("press_state", key_state, 0);
    repeat (500 - FLAG_LAT) @(negedge Clk);
    check("press_flags", flag_cnt - f0, 1);
    check("press_no_long", long_cnt - l0, 0);
    key_in = 1'b1;
    wait_flag(300, lat);
    check("release_lat", lat, FLAG_LAT);
    check("release_state", key_state, 1);
    repeat (50) @(negedge Clk);

    // Short glitch must not qualify
    f0 = flag_cnt;
    key_in = 1'b0;
    repeat (60) @(negedge Clk);
    key_in = 1'b1;
    repeat (300) @(negedge Clk);
    check("glitch_flags", flag_cnt - f0, 0);
    check("glitch_state", key_state, 1);

    // Bouncy press then bouncy release
    f0 = flag_cnt;
    bounce(1'b0);
    check("bounce_press_quiet", flag_cnt - f0, 0);
    wait_flag(300, lat);
    check("bounce_press_lat", lat, FLAG_LAT);
    check("bounce_press_state", key_state, 0);
    repeat (100) @(negedge Clk);
    f0 = flag_cnt;
    bounce(1'b1);
    check("bounce_rel_quiet", flag_cnt - f0, 0);
    wait_flag(300, lat);
    check("bounce_rel_lat", lat, FLAG_LAT);
    check("bounce_rel_state", key_state, 1);
    repeat (50) @(negedge Clk);

    // Long hold
    l0 = long_cnt;
    key_in = 1'b0;
    wait_flag(300, lat);
    check("hold_press_lat", lat, FLAG_LAT);
`ifdef KEY_FILTER_LONG_PRESS_EN
    wait_long(1500, lat);
    check("long_lat", lat, LONG_MAX + 1);
    repeat (3000 - FLAG_LAT - lat) @(negedge Clk);
    check("long_count", long_cnt - l0, 1);
`else
    repeat (3000 - FLAG_LAT) @(negedge Clk);
    check("long_count", long_cnt - l0, 0);
`endif
    key_in = 1'b1;
    wait_flag(300, lat);
    check("hold_release_lat", lat, FLAG_LAT);
    repeat (50) @(negedge Clk);

    // Reset mid-FILTER0 with key held low
    key_in = 1'b0;
    repeat (50) @(negedge Clk);
    #2 Rst_n = 1'b0;
    #1;
    check("rstf0_flag", key_flag, 0);
    check("rstf0_state", key_state, 1);
    check("rstf0_long", key_long, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      check("rstf0_hold_flag", key_flag, 0);
    end
    Rst_n = 1'b1;
    wait_flag(300, lat);
    check("rstf0_lat", lat, FLAG_LAT);
    check("rstf0_state_after", key_state, 0);

    // Reset while pressed forces released level at once
    repeat (20) @(negedge Clk);
    #2 Rst_n = 1'b0;
    #1;
    check("rstdn_state", key_state, 1);
    check("rstdn_flag", key_flag, 0);
    repeat (5) @(negedge Clk);
    Rst_n = 1'b1;
    wait_flag(300, lat);
    check("rstdn_lat", lat, FLAG_LAT);
    key_in = 1'b1;
    repeat (200) @(negedge Clk);

    // Random holds, including lengths around both thresholds
    for (int s = 0; s < 60; s++) begin
      int kind;
      int len;
      kind = $urandom_range(0, 9);
      if (kind < 4)      len = $urandom_range(1, 60);
      else if (kind < 6) len = $urandom_range(CNT_MAX - 2, CNT_MAX + 7);
      else if (kind < 9) len = $urandom_range(150, 400);
      else               len = $urandom_range(CNT_MAX + LONG_MAX - 5, CNT_MAX + LONG_MAX + 10);
      key_in = ~key_in;
      repeat (len) @(negedge Clk);
    end
    key_in = 1'b1;
    repeat (300) @(negedge Clk);
    check("final_state", key_state, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
